// File: rtl/fifo_flags.sv
// fifo_flags: parametrised synchronous FIFO with count, level flags, sticky errors and flush.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is a registered read port.
module fifo_flags #(
    parameter int N = 4,
    parameter int M = 2,
    parameter int AF_LEVEL = 3,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic [M-1:0]  in,
    input  logic          push,
    input  logic          pop,
    output logic [M-1:0]  out,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow
);
    localparam int PW = $clog2(N);

    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d, underflow_q, underflow_d;
    logic          push_ok, pop_ok, wr_en;
    logic [M-1:0]  mem_q [N];

    assign full        = count_q == CW'(N);
    assign empty       = count_q == '0;
    assign almost_full = count_q >= CW'(AF_LEVEL);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    always_comb begin
        pop_ok      = pop & ~empty;
        push_ok     = push & (~full | pop_ok);
        wr_en       = ~clr & push_ok;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (~clr & push & ~push_ok);
        underflow_d = underflow_q | (~clr & pop & ~pop_ok);
        if (clr) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // explicit wrap keeps non-power-of-2 depths from ever indexing slot N
            if (push_ok) wr_ptr_d = (wr_ptr_q == PW'(N - 1)) ? '0 : wr_ptr_q + PW'(1);
            if (pop_ok) rd_ptr_d = (rd_ptr_q == PW'(N - 1)) ? '0 : rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // storage is never cleared; only the pointers and count define validity
    always_ff @(posedge clk) begin
        if (reset && wr_en) mem_q[wr_ptr_q] <= in;
    end

`ifdef FIFO_FWFT_EN
    assign out = empty ? '0 : mem_q[rd_ptr_q];
`else
    logic [M-1:0] out_q, out_d;

    assign out = out_q;

    always_comb begin
        out_d = out_q;
        if (clr) out_d = '0;
        else if (pop_ok) out_d = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (!reset) out_q <= '0;
        else out_q <= out_d;
    end
`endif

endmodule

// File: tb/tb_fifo_flags.sv
// tb_fifo_flags: drives an N=5 and an N=4 fifo_flags with shared stimulus and checks
// both against a queue-based reference model.
module tb_fifo_flags;
    logic       clk = 1'b0;
    logic       reset = 1'b0, clr = 1'b0, push = 1'b0, pop = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] dout [2];
    logic [2:0] cnt [2];
    logic       full [2], empty [2], af [2], ovf [2], unf [2];

    logic [7:0] mq [2][$];
    logic [7:0] mo [2];
    logic       mov [2], mun [2];
    int         n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    fifo_flags #(.N(5), .M(8), .AF_LEVEL(3)) u5 (
        .clk(clk), .reset(reset), .clr(clr), .in(din), .push(push), .pop(pop),
        .out(dout[0]), .full(full[0]), .empty(empty[0]), .almost_full(af[0]),
        .count(cnt[0]), .overflow(ovf[0]), .underflow(unf[0])
    );

    fifo_flags #(.N(4), .M(8), .AF_LEVEL(3)) u4 (
        .clk(clk), .reset(reset), .clr(clr), .in(din), .push(push), .pop(pop),
        .out(dout[1]), .full(full[1]), .empty(empty[1]), .almost_full(af[1]),
        .count(cnt[1]), .overflow(ovf[1]), .underflow(unf[1])
    );

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int cap;
            bit po, pu;
            cap = (k == 0) ? 5 : 4;
            if (!reset) begin
                mq[k].delete();
                mo[k] = '0;
                mov[k] = 1'b0;
                mun[k] = 1'b0;
            end else if (clr) begin
                mq[k].delete();
                mo[k] = '0;
            end else begin
                po = pop && mq[k].size() > 0;
                pu = push && (mq[k].size() < cap || po);
                if (pop && !po) mun[k] = 1'b1;
                if (push && !pu) mov[k] = 1'b1;
                if (po) mo[k] = mq[k].pop_front();
                if (pu) mq[k].push_back(din);
            end
        end
    endtask

    function automatic logic [7:0] exp_out(int k);
`ifdef FIFO_FWFT_EN
        return (mq[k].size() > 0) ? mq[k][0] : 8'h00;
`else
        return mo[k];
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        push = 1'b0; pop = 1'b0; clr = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; push = 1'b1; din = 8'h77;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (cnt[k] !== 3'd0) begin n_err++; $display("FAIL reset_count[%0d] got %0d want 0", k, cnt[k]); end
            n_cmp++; if (empty[k] !== 1'b1 || full[k] !== 1'b0) begin n_err++; $display("FAIL reset_flags[%0d] got empty=%b full=%b want 1 0", k, empty[k], full[k]); end
            n_cmp++; if (dout[k] !== 8'h00) begin n_err++; $display("FAIL reset_out[%0d] got %h want 00", k, dout[k]); end
            n_cmp++; if (ovf[k] !== 1'b0 || unf[k] !== 1'b0) begin n_err++; $display("FAIL reset_err[%0d] got ovf=%b unf=%b want 0 0", k, ovf[k], unf[k]); end
        end
        reset = 1'b1;
        idle();
    endtask

    task automatic test_order_wrap();
        logic [7:0] want;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            int n;
            n = (r == 0) ? 5 : 3;
            for (int i = 0; i < n; i++) begin
                push = 1'b1; din = 8'((r == 0 ? 8'h11 : 8'h21) + i);
                tick();
                n_cmp++; if (cnt[0] !== 3'(i + 1)) begin n_err++; $display("FAIL wrap_count got %0d want %0d", cnt[0], i + 1); end
                n_cmp++; if (af[0] !== (i + 1 >= 3) || full[0] !== (i + 1 == 5)) begin n_err++; $display("FAIL wrap_flags count=%0d got af=%b full=%b want %b %b", i + 1, af[0], full[0], i + 1 >= 3, i + 1 == 5); end
            end
            push = 1'b0;
            for (int i = 0; i < n; i++) begin
                want = 8'((r == 0 ? 8'h11 : 8'h21) + i);
                pop = 1'b1;
`ifdef FIFO_FWFT_EN
                n_cmp++; if (dout[0] !== want) begin n_err++; $display("FAIL wrap_order got %h want %h", dout[0], want); end
                tick();
`else
                tick();
                n_cmp++; if (dout[0] !== want) begin n_err++; $display("FAIL wrap_order got %h want %h", dout[0], want); end
`endif
            end
            pop = 1'b0;
            n_cmp++; if (empty[0] !== 1'b1) begin n_err++; $display("FAIL wrap_empty got %b want 1", empty[0]); end
        end
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (ovf[k] !== mov[k] || unf[k] !== mun[k]) begin n_err++; $display("FAIL wrap_err[%0d] got %b%b want %b%b", k, ovf[k], unf[k], mov[k], mun[k]); end
        end
    endtask

    task automatic test_full();
        logic [7:0] seq [4];
        seq[0] = 8'hA1; seq[1] = 8'hA2; seq[2] = 8'hA3; seq[3] = 8'hBB;
        do_reset();
        push = 1'b1;
        for (int i = 0; i < 4; i++) begin din = 8'(8'hA0 + i); tick(); end
        n_cmp++; if (full[1] !== 1'b1 || cnt[1] !== 3'd4) begin n_err++; $display("FAIL full_fill got full=%b count=%0d want 1 4", full[1], cnt[1]); end
        din = 8'hAA;
        tick();
        n_cmp++; if (ovf[1] !== 1'b1 || cnt[1] !== 3'd4) begin n_err++; $display("FAIL full_overflow got ovf=%b count=%0d want 1 4", ovf[1], cnt[1]); end
        din = 8'hBB; pop = 1'b1;
`ifdef FIFO_FWFT_EN
        n_cmp++; if (dout[1] !== 8'hA0) begin n_err++; $display("FAIL full_pushpop_out got %h want a0", dout[1]); end
        tick();
`else
        tick();
        n_cmp++; if (dout[1] !== 8'hA0) begin n_err++; $display("FAIL full_pushpop_out got %h want a0", dout[1]); end
`endif
        n_cmp++; if (cnt[1] !== 3'd4) begin n_err++; $display("FAIL full_pushpop_count got %0d want 4", cnt[1]); end
        push = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef FIFO_FWFT_EN
            n_cmp++; if (dout[1] !== seq[i]) begin n_err++; $display("FAIL full_drain got %h want %h", dout[1], seq[i]); end
            tick();
`else
            tick();
            n_cmp++; if (dout[1] !== seq[i]) begin n_err++; $display("FAIL full_drain got %h want %h", dout[1], seq[i]); end
`endif
        end
        pop = 1'b0;
    endtask

    task automatic test_empty();
        do_reset();
        pop = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (unf[k] !== 1'b1 || cnt[k] !== 3'd0) begin n_err++; $display("FAIL empty_underflow[%0d] got unf=%b count=%0d want 1 0", k, unf[k], cnt[k]); end
        end
        push = 1'b1; din = 8'h05;
        tick();
        n_cmp++; if (cnt[0] !== 3'd1 || empty[0] !== 1'b0) begin n_err++; $display("FAIL empty_pushpop got count=%0d empty=%b want 1 0", cnt[0], empty[0]); end
        push = 1'b0;
`ifdef FIFO_FWFT_EN
        n_cmp++; if (dout[0] !== 8'h05) begin n_err++; $display("FAIL empty_head got %h want 05", dout[0]); end
        tick();
        n_cmp++; if (dout[0] !== 8'h00) begin n_err++; $display("FAIL empty_fwft_zero got %h want 00", dout[0]); end
`else
        n_cmp++; if (dout[0] !== 8'h00) begin n_err++; $display("FAIL empty_hold got %h want 00", dout[0]); end
        tick();
        n_cmp++; if (dout[0] !== 8'h05) begin n_err++; $display("FAIL empty_pop got %h want 05", dout[0]); end
`endif
        n_cmp++; if (cnt[0] !== 3'd0) begin n_err++; $display("FAIL empty_final got %0d want 0", cnt[0]); end
        pop = 1'b0;
    endtask

    task automatic test_clr();
        do_reset();
        pop = 1'b1;
        tick();
        pop = 1'b0; push = 1'b1;
        for (int i = 0; i < 4; i++) begin din = 8'(8'h31 + i); tick(); end
        push = 1'b0; pop = 1'b1;
        tick();
        n_cmp++; if (cnt[0] !== 3'd3 || cnt[1] !== 3'd3) begin n_err++; $display("FAIL clr_setup got %0d %0d want 3 3", cnt[0], cnt[1]); end
        pop = 1'b0; push = 1'b1; clr = 1'b1; din = 8'hEE;
        tick();
        clr = 1'b0; push = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (cnt[k] !== 3'd0 || empty[k] !== 1'b1) begin n_err++; $display("FAIL clr_state[%0d] got count=%0d empty=%b want 0 1", k, cnt[k], empty[k]); end
            n_cmp++; if (dout[k] !== 8'h00) begin n_err++; $display("FAIL clr_out[%0d] got %h want 00", k, dout[k]); end
            n_cmp++; if (unf[k] !== 1'b1 || ovf[k] !== 1'b0) begin n_err++; $display("FAIL clr_err_hold[%0d] got ovf=%b unf=%b want 0 1", k, ovf[k], unf[k]); end
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (unf[k] !== 1'b0 || ovf[k] !== 1'b0) begin n_err++; $display("FAIL clr_reset_err[%0d] got ovf=%b unf=%b want 0 0", k, ovf[k], unf[k]); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            push  = 1'($urandom_range(0, 99) < 55);
            pop   = 1'($urandom_range(0, 99) < 50);
            clr   = 1'($urandom_range(0, 99) < 3);
            reset = 1'($urandom_range(0, 99) >= 2);
            din   = 8'($urandom);
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (cnt[k] !== 3'(mq[k].size()) || empty[k] !== (mq[k].size() == 0) ||
                    full[k] !== (mq[k].size() == (k == 0 ? 5 : 4)) || af[k] !== (mq[k].size() >= 3)) begin
                    n_err++;
                    $display("FAIL rand_flags[%0d] cyc %0d got count=%0d e=%b f=%b af=%b want count=%0d", k, c, cnt[k], empty[k], full[k], af[k], mq[k].size());
                end
                n_cmp++;
                if (dout[k] !== exp_out(k) || ovf[k] !== mov[k] || unf[k] !== mun[k]) begin
                    n_err++;
                    $display("FAIL rand_data[%0d] cyc %0d got out=%h ovf=%b unf=%b want out=%h ovf=%b unf=%b", k, c, dout[k], ovf[k], unf[k], exp_out(k), mov[k], mun[k]);
                end
            end
        end
        reset = 1'b1;
        idle();
    endtask

    initial begin
        test_reset();
        test_order_wrap();
        test_full();
        test_empty();
        test_clr();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
